uart_byte_rx: RTL
=================

UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clk cycles per UART bit period (100 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port rxd  input  1  raw asynchronous serial line, idle high.
REQ-005 SHALL have port rx_valid  output  1  one-cycle pulse when a good byte is available; no backpressure.
REQ-006 SHALL have port rx_byte  output  8  received byte; held stable until the next rx_valid.
REQ-007 SHALL have port frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-008 SHALL have port parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 when parity is compiled out.

Function
REQ-009 SHALL pass rxd through a 2-flop synchronizer reset to 1; all decoding uses the synchronized value rxd_s.
REQ-010 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH; the bit counter is $clog2(CLKS_PER_BIT) bits wide, the bit index is 3 bits.
REQ-011 IDLE: rxd_s==0 -> START, with the counter cleared.
REQ-012 START: at count CLKS_PER_BIT/2-1 (integer divide), sample rxd_s; 0 -> DATA with counter cleared; 1 -> IDLE as a glitch, with no output pulse.
REQ-013 DATA: sample every CLKS_PER_BIT cycles, LSB first, into a shift register; after bit 7 -> PARITY if compiled in, else STOP.
REQ-014 STOP: sample after CLKS_PER_BIT cycles; 1 -> rx_byte <= shift register and rx_valid pulses the following cycle, -> IDLE; 0 -> frame_err pulses, rx_byte is unchanged, no rx_valid, -> WAIT_HIGH.
REQ-015 WAIT_HIGH: remain until rxd_s==1, then -> IDLE; a held-low line (break) SHALL yield exactly one frame_err.
REQ-016 rx_valid, frame_err and parity_err SHALL be mutually exclusive and each high for exactly one cycle per event.
REQ-017 Latency: rx_valid SHALL rise exactly 1 cycle after the stop-bit mid-sample, and the synchronizer adds 2 cycles from rxd.
REQ-018 A start edge arriving in the cycle the FSM returns to IDLE SHALL be accepted, so back-to-back bytes with one stop bit are received without loss.
REQ-019 Output timing SHALL be compatible with direct connection to the frame decoder's rx_valid/rx_byte inputs.

Reset
REQ-020 On rst_n low, asynchronously: state=IDLE, counters=0, rx_byte=8'h00, rx_valid=0, frame_err=0, parity_err=0, synchronizer flops=1.
REQ-021 Reset mid-byte SHALL discard the partial byte; after release, reception resumes at the next falling edge with no output pulse for the aborted byte.

Configuration
REQ-022 Macro UART_BYTE_RX_PARITY_EN defined: one even-parity bit follows bit 7, sampled in PARITY one bit period after bit 7.
REQ-023 With UART_BYTE_RX_PARITY_EN, a mismatch SHALL still run STOP: on stop=1, parity_err pulses instead of rx_valid and rx_byte is unchanged; on stop=0, frame_err takes precedence.
REQ-024 Macro undefined: no PARITY state, 8N1 framing, parity_err tied to 0.

Verification (CLKS_PER_BIT=16)
REQ-025 Send 8'hA5 (8N1) -> exactly one rx_valid, rx_byte=8'hA5, 1 cycle after the stop mid-sample; no error pulses.
REQ-026 Drive rxd low for 4 cycles then high -> no rx_valid or frame_err, FSM back to IDLE; a following 8'h3C is received correctly.
REQ-027 Send 8'h00 with stop bit low, then hold the line low for 40 bit times -> one frame_err pulse, no rx_valid; after the line goes high, 8'hFF is received correctly.
REQ-028 Back-to-back 8'h00, 8'hFF, 8'h55 with no idle gap -> three rx_valid pulses with bytes in order.
REQ-029 Assert rst_n low during bit 4 of 8'hC3 -> outputs reset immediately and no pulse; the next 8'h81 is received correctly.
REQ-030 With UART_BYTE_RX_PARITY_EN: 8'h07 with parity bit 1 -> rx_valid and byte 8'h07; same byte with parity bit 0 -> one parity_err pulse, no rx_valid, rx_byte still 8'h07 from before.

Source files
------------

// File: rtl/uart_byte_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_byte_rx
// Description : Oversampling UART byte receiver (8N1, or 8E1 when the
//               UART_BYTE_RX_PARITY_EN macro is defined), mid-bit sampling.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_full_last = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_BYTE_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;
`endif

    logic               r_sync1;
    logic               r_sync2;
    logic               w_rxd_s;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [2:0]         r_idx;
    logic [2:0]         w_idx_nxt;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_nxt;
    logic [7:0]         r_rx_byte;
    logic [7:0]         w_byte_nxt;
    logic               r_rx_valid;
    logic               w_valid_nxt;
    logic               r_frame_err;
    logic               w_ferr_nxt;
    logic               w_tick;

    // Two-flop synchronizer; resets to the idle (high) line level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxd_s = r_sync2;
    assign w_tick  = (r_cnt == c_full_last);

`ifdef UART_BYTE_RX_PARITY_EN
    logic r_par_bad;
    logic w_par_bad_nxt;
    logic r_parity_err;
    logic w_perr_nxt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + c_cnt_w'(1);
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_byte_nxt  = r_rx_byte;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
`ifdef UART_BYTE_RX_PARITY_EN
        w_par_bad_nxt = r_par_bad;
        w_perr_nxt    = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                w_idx_nxt = 3'd0;
                if (!w_rxd_s) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                // Re-check the start bit at its centre to reject glitches
                if (r_cnt == c_half_last) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = w_rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_rxd_s, r_shift[7:1]};
                    w_idx_nxt   = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
`ifdef UART_BYTE_RX_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_BYTE_RX_PARITY_EN
            PARITY: begin
                if (w_tick) begin
                    w_cnt_nxt     = '0;
                    w_par_bad_nxt = ^{r_shift, w_rxd_s};
                    w_state_nxt   = STOP;
                end
            end
`endif
            STOP: begin
                if (w_tick) begin
                    w_cnt_nxt = '0;
                    if (!w_rxd_s) begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = WAIT_HIGH;
                    end else begin
                        w_state_nxt = IDLE;
`ifdef UART_BYTE_RX_PARITY_EN
                        if (r_par_bad) begin
                            w_perr_nxt = 1'b1;
                        end else begin
                            w_valid_nxt = 1'b1;
                            w_byte_nxt  = r_shift;
                        end
`else
                        w_valid_nxt = 1'b1;
                        w_byte_nxt  = r_shift;
`endif
                    end
                end
            end
            WAIT_HIGH: begin
                // A held-low break reports once, then waits for the line to idle
                w_cnt_nxt = '0;
                if (w_rxd_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_idx       <= 3'd0;
            r_shift     <= 8'h00;
            r_rx_byte   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_rx_byte   <= w_byte_nxt;
            r_rx_valid  <= w_valid_nxt;
            r_frame_err <= w_ferr_nxt;
        end
    end

`ifdef UART_BYTE_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_par_bad    <= w_par_bad_nxt;
            r_parity_err <= w_perr_nxt;
        end
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_valid  = r_rx_valid;
    assign rx_byte   = r_rx_byte;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire
